gci_std_display_vram_write_buffer: RTL and testbench

Pixel write buffer between the display draw engines (character, clear) and the VRAM memory port. Accepts single-pixel writes (address, 24-bit RGB) with valid/busy flow control, stores them in a first-word-fall-through FIFO, and drains them to the memory interface with its own valid/busy handshake. This decouples draw-engine progress from memory arbitration stalls.

---
 rtl/gci_std_display_pkg.sv | 6 +
 rtl/gci_std_display_vram_write_buffer_if.sv | 28 ++
 rtl/gci_std_display_sync_fifo.sv | 68 ++++++
 rtl/gci_std_display_vram_write_buffer.sv | 63 ++++++
 tb/tb_gci_std_display_vram_write_buffer.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/gci_std_display_pkg.sv
// Shared display-path constants: pixel widths and the default VRAM address width.
package gci_std_display_pkg;
    localparam int PIXEL_W       = 24;
    localparam int RGB565_W      = 16;
    localparam int MEM_ADDR_N_DF = 23;
endpackage

// File: rtl/gci_std_display_vram_write_buffer_if.sv
// Draw-engine to VRAM write-buffer bus: upstream pixel writes plus the memory-side head port.
interface gci_std_display_vram_write_buffer_if #(
    parameter int P_MEM_ADDR_N   = gci_std_display_pkg::MEM_ADDR_N_DF,
    parameter int P_FIFO_DEPTH_N = 4
);
    import gci_std_display_pkg::*;

    logic                      iIF_VALID;
    logic                      oIF_BUSY;
    logic [P_MEM_ADDR_N-1:0]   iIF_ADDR;
    logic [PIXEL_W-1:0]        iIF_DATA;
    logic                      oMEM_VALID;
    logic                      iMEM_BUSY;
    logic [P_MEM_ADDR_N-1:0]   oMEM_ADDR;
    logic [PIXEL_W-1:0]        oMEM_DATA;
    logic [P_FIFO_DEPTH_N:0]   oCOUNT;
    logic                      oEMPTY;

    // slave: the write buffer itself; master: the draw engines and memory port around it
    modport slave (
        input  iIF_VALID, iIF_ADDR, iIF_DATA, iMEM_BUSY,
        output oIF_BUSY, oMEM_VALID, oMEM_ADDR, oMEM_DATA, oCOUNT, oEMPTY
    );
    modport master (
        output iIF_VALID, iIF_ADDR, iIF_DATA, iMEM_BUSY,
        input  oIF_BUSY, oMEM_VALID, oMEM_ADDR, oMEM_DATA, oCOUNT, oEMPTY
    );
endinterface

// File: rtl/gci_std_display_sync_fifo.sv
// Generic first-word-fall-through FIFO; head entry is readable as soon as count is non-zero.
module gci_std_display_sync_fifo #(
    parameter int P_WIDTH   = 24,
    parameter int P_DEPTH_N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 srst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [P_WIDTH-1:0]   wdata,
    output logic [P_WIDTH-1:0]   rdata,
    output logic [P_DEPTH_N:0]   count,
    output logic                 full,
    output logic                 empty
);
    localparam int                 DEPTH    = 1 << P_DEPTH_N;
    localparam logic [P_DEPTH_N:0] FULL_CNT = (P_DEPTH_N + 1)'(DEPTH);

    logic [P_WIDTH-1:0]   mem [DEPTH];
    logic [P_DEPTH_N-1:0] wptr_q, wptr_d;
    logic [P_DEPTH_N-1:0] rptr_q, rptr_d;
    logic [P_DEPTH_N:0]   count_q, count_d;
    logic                 do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // synchronous reset discards pending entries but leaves storage contents alone
        if (srst) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !srst) mem[wptr_q] <= wdata;
    end

    assign rdata = mem[rptr_q];
    assign count = count_q;
endmodule

// File: rtl/gci_std_display_vram_write_buffer.sv
// Pixel write buffer between the draw engines and the VRAM port.
// Define GCI_STD_DISPLAY_VRAM_WB_RGB565_EN to pack pixels to RGB565 on the write side.
module gci_std_display_vram_write_buffer
    import gci_std_display_pkg::*;
#(
    parameter int P_MEM_ADDR_N   = MEM_ADDR_N_DF,
    parameter int P_FIFO_DEPTH_N = 4
) (
    input  logic iCLOCK,
    input  logic inRESET,
    input  logic iRESET_SYNC,
    gci_std_display_vram_write_buffer_if.slave bus
);
`ifdef GCI_STD_DISPLAY_VRAM_WB_RGB565_EN
    localparam int STORE_W = RGB565_W;
`else
    localparam int STORE_W = PIXEL_W;
`endif
    localparam int ENTRY_W = P_MEM_ADDR_N + STORE_W;

    logic [STORE_W-1:0] wr_pixel;
    logic [ENTRY_W-1:0] wr_entry, rd_entry;
    logic               fifo_full, fifo_empty;
    logic               if_busy, push, pop;

`ifdef GCI_STD_DISPLAY_VRAM_WB_RGB565_EN
    assign wr_pixel = {bus.iIF_DATA[23:19], bus.iIF_DATA[15:10], bus.iIF_DATA[7:3]};
`else
    assign wr_pixel = bus.iIF_DATA;
`endif

    // busy depends only on registered fill level and the reset input, never on valid or mem busy
    assign if_busy  = fifo_full || iRESET_SYNC;
    assign push     = bus.iIF_VALID && !if_busy;
    assign pop      = !fifo_empty && !bus.iMEM_BUSY;
    assign wr_entry = {bus.iIF_ADDR, wr_pixel};

    gci_std_display_sync_fifo #(
        .P_WIDTH   (ENTRY_W),
        .P_DEPTH_N (P_FIFO_DEPTH_N)
    ) u_fifo (
        .clk   (iCLOCK),
        .rst_n (inRESET),
        .srst  (iRESET_SYNC),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .count (bus.oCOUNT),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.oIF_BUSY   = if_busy;
    assign bus.oMEM_VALID = !fifo_empty;
    assign bus.oEMPTY     = fifo_empty;
    assign bus.oMEM_ADDR  = rd_entry[ENTRY_W-1:STORE_W];
`ifdef GCI_STD_DISPLAY_VRAM_WB_RGB565_EN
    assign bus.oMEM_DATA  = {8'h00, rd_entry[STORE_W-1:0]};
`else
    assign bus.oMEM_DATA  = rd_entry[STORE_W-1:0];
`endif
endmodule

// File: tb/tb_gci_std_display_vram_write_buffer.sv
// Directed and random-backpressure bench for the VRAM write buffer with a queue scoreboard.
module tb_gci_std_display_vram_write_buffer;
    localparam int AW = 23;
    localparam int DN = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic srst  = 1'b0;
    always #5 clk = ~clk;

    gci_std_display_vram_write_buffer_if #(.P_MEM_ADDR_N(AW), .P_FIFO_DEPTH_N(DN)) bus ();

    gci_std_display_vram_write_buffer #(.P_MEM_ADDR_N(AW), .P_FIFO_DEPTH_N(DN)) u_dut (
        .iCLOCK      (clk),
        .inRESET     (rst_n),
        .iRESET_SYNC (srst),
        .bus         (bus.slave)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [23:0]   d;
    } ent_t;

    ent_t q[$];
    int   n_vec   = 0;
    int   n_miss  = 0;
    int   max_cnt = 0;
    bit   verbose = 1'b0;
    bit   last_acc;
    logic [23:0] data_reg;

    function automatic logic [23:0] exp_data(input logic [23:0] d);
`ifdef GCI_STD_DISPLAY_VRAM_WB_RGB565_EN
        return {8'h00, d[23:19], d[15:10], d[7:3]};
`else
        return d;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic cycle(input logic v, input logic [AW-1:0] a, input logic [23:0] d,
                         input logic mb, input logic sr);
        bit e_busy, e_valid;
        bus.iIF_VALID = v;
        bus.iIF_ADDR  = a;
        bus.iIF_DATA  = d;
        bus.iMEM_BUSY = mb;
        srst          = sr;
        #1;
        e_busy  = (q.size() == 16) || sr;
        e_valid = (q.size() != 0);
        chk("busy",  bus.oIF_BUSY,   e_busy);
        chk("valid", bus.oMEM_VALID, e_valid);
        chk("count", bus.oCOUNT,     64'(q.size()));
        chk("empty", bus.oEMPTY,     q.size() == 0);
        if (e_valid) begin
            chk("head_addr", bus.oMEM_ADDR, q[0].a);
            chk("head_data", bus.oMEM_DATA, exp_data(q[0].d));
        end
        if (int'(bus.oCOUNT) > max_cnt) max_cnt = int'(bus.oCOUNT);
        last_acc = 1'b0;
        if (sr) begin
            q.delete();
        end else begin
            if (e_valid && !mb) begin
                if (verbose) $display("mem write addr=%06h data=%06h", q[0].a, exp_data(q[0].d));
                void'(q.pop_front());
            end
            if (v && !e_busy) begin
                q.push_back('{a, d});
                last_acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0);
        chk("drain_done", 64'(q.size()), 0);
    endtask

    initial begin
        bus.iIF_VALID = 1'b0;
        bus.iIF_ADDR  = '0;
        bus.iIF_DATA  = '0;
        bus.iMEM_BUSY = 1'b0;
        #12;
        chk("rst_valid", bus.oMEM_VALID, 1'b0);
        chk("rst_count", bus.oCOUNT,     0);
        chk("rst_empty", bus.oEMPTY,     1'b1);
        chk("rst_busy",  bus.oIF_BUSY,   1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single write
        verbose = 1'b1;
        cycle(1'b1, 23'h000123, 24'hFF8040, 1'b0, 1'b0);
        chk("t1_valid", bus.oMEM_VALID, 1'b1);
        chk("t1_addr",  bus.oMEM_ADDR,  23'h000123);
`ifdef GCI_STD_DISPLAY_VRAM_WB_RGB565_EN
        chk("t1_data",  bus.oMEM_DATA,  24'h00FC08);
`else
        chk("t1_data",  bus.oMEM_DATA,  24'hFF8040);
`endif
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        chk("t1_empty", bus.oEMPTY, 1'b1);

        // fill to 16 with memory stalled, 17th held upstream
        for (int i = 0; i < 17; i++) begin
            data_reg = 24'hA00000 | 24'(i * 24'h010203);
            cycle(1'b1, 23'(32'h1000 + i), data_reg, 1'b1, 1'b0);
        end
        chk("fill_count", bus.oCOUNT,   16);
        chk("fill_busy",  bus.oIF_BUSY, 1'b1);
        data_reg = 24'hA00000 | 24'(16 * 24'h010203);
        begin
            bit held = 1'b1;
            for (int i = 0; i < 10 && held; i++) begin
                cycle(1'b1, 23'h1010, data_reg, 1'b0, 1'b0);
                if (last_acc) held = 1'b0;
            end
            chk("fill_17th_taken", held, 1'b0);
        end
        drain();

        // streaming burst, no backpressure
        verbose = 1'b0;
        max_cnt = 0;
        for (int i = 0; i < 112; i++) begin
            data_reg = 24'(i * 24'h030507);
            cycle(1'b1, 23'(32'h4000 + i), data_reg, 1'b0, 1'b0);
        end
        drain();
        chk("stream_max_count", 64'(max_cnt), 1);

        // count 8 held across pointer wrap with simultaneous push/pop
        for (int i = 0; i < 8; i++) cycle(1'b1, 23'(32'h5000 + i), 24'(32'h111111 * i), 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 23'(32'h5100 + i), 24'(32'h0F0F0F + i), 1'b0, 1'b0);
        chk("wrap_count", bus.oCOUNT, 8);
        drain();

        // synchronous reset with 5 pending, accept attempt ignored
        for (int i = 0; i < 5; i++) cycle(1'b1, 23'(32'h6000 + i), 24'(32'h202020 + i), 1'b1, 1'b0);
        chk("srst_pre_count", bus.oCOUNT, 5);
        cycle(1'b1, 23'h6FFF, 24'h123456, 1'b1, 1'b1);
        chk("srst_valid", bus.oMEM_VALID, 1'b0);
        chk("srst_count", bus.oCOUNT,     0);
        chk("srst_empty", bus.oEMPTY,     1'b1);

        // asynchronous reset pulse mid-cycle with 5 pending
        for (int i = 0; i < 5; i++) cycle(1'b1, 23'(32'h7000 + i), 24'(32'h303030 + i), 1'b1, 1'b0);
        bus.iIF_VALID = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.oMEM_VALID, 1'b0);
        chk("arst_count", bus.oCOUNT,     0);
        chk("arst_empty", bus.oEMPTY,     1'b1);
        q.delete();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // random traffic with random memory stalls
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)), 23'($urandom), 24'($urandom),
                  1'($urandom_range(0, 2) == 0), 1'b0);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
